// File: rtl/shiftreg_sequencer_if.sv
// shiftreg_sequencer_if: command handshake between a requester and the shift register sequencer
interface shiftreg_sequencer_if #(
    parameter int DATASIZE = 8,
    parameter int CNTSIZE  = $clog2(DATASIZE) + 1
);
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic                cmd_load_i;
    logic [DATASIZE-1:0] cmd_value_i;
    logic                cmd_dir_i;
    logic [CNTSIZE-1:0]  cmd_count_i;
    logic [DATASIZE-1:0] cmd_fill_i;
    logic                abort_i;
    modport master (
        output cmd_valid_i, cmd_load_i, cmd_value_i, cmd_dir_i, cmd_count_i, cmd_fill_i, abort_i,
        input  cmd_ready_o
    );
    modport slave (
        input  cmd_valid_i, cmd_load_i, cmd_value_i, cmd_dir_i, cmd_count_i, cmd_fill_i, abort_i,
        output cmd_ready_o
    );
endinterface

// File: rtl/shiftreg_sequencer.sv
// shiftreg_sequencer: turns load/shift commands into cycle-by-cycle mode and serial-in drive for a 4-mode shift register
module shiftreg_sequencer #(
    parameter int DATASIZE = 8,
    parameter int CNTSIZE  = $clog2(DATASIZE) + 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    shiftreg_sequencer_if.slave cmd,
    output logic [1:0]          mode_o,
    output logic [DATASIZE-1:0] load_value_o,
    output logic                ser_in_msb_o,
    output logic                ser_in_lsb_o,
    output logic                busy_o,
    output logic                done_o
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
    state_t              r_state;
    state_t              w_next;
    logic [DATASIZE-1:0] r_value;
    logic [DATASIZE-1:0] r_fill;
    logic                r_dir;
    logic [CNTSIZE-1:0]  r_count;
    logic [CNTSIZE-1:0]  r_k;
    logic [CNTSIZE-1:0]  w_count;
    logic [DATASIZE-1:0] w_fill_shifted;
    logic                w_fill_bit;
    logic                w_accept;
    logic                w_last;
    assign w_count        = (cmd.cmd_count_i > CNTSIZE'(DATASIZE)) ? CNTSIZE'(DATASIZE) : cmd.cmd_count_i;
    assign w_accept       = (r_state == S_IDLE) && cmd.cmd_valid_i;
    assign w_last         = (r_k + CNTSIZE'(1)) == r_count;
    assign w_fill_shifted = r_fill >> r_k;
    assign w_fill_bit     = w_fill_shifted[0];
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_value <= '0;
            r_fill  <= '0;
            r_dir   <= 1'b0;
            r_count <= '0;
            r_k     <= '0;
        end else if (w_accept) begin
            r_value <= cmd.cmd_value_i;
            r_fill  <= cmd.cmd_fill_i;
            r_dir   <= cmd.cmd_dir_i;
            r_count <= w_count;
            r_k     <= '0;
        end else if (r_state == S_SHIFT) begin
            r_k     <= r_k + CNTSIZE'(1);
        end
    end
    // abort is only honoured while the register is being driven
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = !cmd.cmd_valid_i ? S_IDLE :
                              cmd.cmd_load_i ? S_LOAD : (w_count != '0) ? S_SHIFT : S_DONE;
            S_LOAD:  w_next = (cmd.abort_i || r_count == '0) ? S_DONE : S_SHIFT;
            S_SHIFT: w_next = (cmd.abort_i || w_last) ? S_DONE : S_SHIFT;
            default: w_next = S_IDLE;
        endcase
    end
    always_comb begin
        mode_o          = (r_state == S_LOAD) ? 2'b11 :
                          (r_state == S_SHIFT) ? (r_dir ? 2'b10 : 2'b01) : 2'b00;
        load_value_o    = r_value;
        ser_in_msb_o    = (r_state == S_SHIFT) && r_dir && w_fill_bit;
        ser_in_lsb_o    = (r_state == S_SHIFT) && !r_dir && w_fill_bit;
        busy_o          = (r_state == S_LOAD) || (r_state == S_SHIFT);
        done_o          = r_state == S_DONE;
        cmd.cmd_ready_o = r_state == S_IDLE;
    end
endmodule
